// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// stall-counter width.
package fifo_arb_pkg;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  localparam int unsigned StallCntW = 16;

  function automatic logic [StallCntW-1:0] stall_sat_inc(input logic [StallCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester with req set, searching
// upward from ptr+1 with wrap-around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [PtrW-1:0]    idx,
  output logic               valid
);

  int unsigned cand;

  always_comb begin
    sel   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        sel[cand] = 1'b1;
        idx       = PtrW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting bursts of up to MAX_BURST words on one FIFO
// write port. Define FIFO_WR_ARB_STATS_EN to add the stall_cnt output.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WITH = 16,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_WITH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [DATA_WITH-1:0]         fifo_data_in
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [StallCntW-1:0]         stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  logic [0:0]         state_q, state_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_sel;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_valid;
  logic               owner_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req = req[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    grant        = '0;
    ack          = '0;
    fifo_write   = 1'b0;
    fifo_data_in = '0;
    unique case (state_q)
      StIdle: begin
        // fifo_full deliberately plays no part in selection.
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        grant[owner_q] = 1'b1;
        fifo_write     = owner_req && !fifo_full;
        ack[owner_q]   = fifo_write;
        fifo_data_in   = req_data[32'(owner_q) * DATA_WITH +: DATA_WITH];
        if (!owner_req) begin
          state_d = StIdle;
          ptr_d   = owner_q;
        end else if (fifo_write) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
            ptr_d   = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= PtrW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == StBurst && owner_req && fifo_full) begin
      stall_cnt_d = stall_sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
